// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t                state, state_next;
  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_hist, data_hist;
  logic                  clk_filt, data_filt, clk_filt_d, fall;
  logic [INH_W-1:0]      inh_cnt, inh_cnt_next;
  logic [WD_W-1:0]       wd_cnt, wd_cnt_next;
  logic [3:0]            fall_cnt, fall_cnt_next;
  logic [9:0]            shift, shift_next;
  logic                  data_low, data_low_next;
  logic                  inh_last, wd_expired;

  // Filters idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_hist   <= '1;
      data_hist  <= '1;
      clk_filt   <= 1'b1;
      data_filt  <= 1'b1;
      clk_filt_d <= 1'b1;
      fall       <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      data_sync  <= {data_sync[0], ps2_data_in};
      clk_hist   <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
      data_hist  <= {data_hist[FILTER_LEN-2:0], data_sync[1]};
      if (&clk_hist)       clk_filt <= 1'b1;
      else if (~|clk_hist) clk_filt <= 1'b0;
      if (&data_hist)       data_filt <= 1'b1;
      else if (~|data_hist) data_filt <= 1'b0;
      clk_filt_d <= clk_filt;
      fall       <= clk_filt_d & ~clk_filt;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state    <= IDLE;
      inh_cnt  <= '0;
      wd_cnt   <= '0;
      fall_cnt <= '0;
      shift    <= '0;
      data_low <= 1'b0;
    end else begin
      state    <= state_next;
      inh_cnt  <= inh_cnt_next;
      wd_cnt   <= wd_cnt_next;
      fall_cnt <= fall_cnt_next;
      shift    <= shift_next;
      data_low <= data_low_next;
    end
  end

  assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

  always_comb begin
    state_next    = state;
    inh_cnt_next  = inh_cnt;
    wd_cnt_next   = wd_cnt;
    fall_cnt_next = fall_cnt;
    shift_next    = shift;
    data_low_next = data_low;
    tx_done       = 1'b0;
    tx_error      = 1'b0;
    wd_expired    = 1'b0;

    if (state inside {REQ, SEND, ACK, WAIT_IDLE}) begin
      if (fall) begin
        wd_cnt_next = '0;
      end else begin
        wd_cnt_next = wd_cnt + 1'b1;
        wd_expired  = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
      end
    end

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_next    = {1'b1, ~^tx_data, tx_data};
          inh_cnt_next  = '0;
          fall_cnt_next = '0;
          data_low_next = 1'b0;
          state_next    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_last) begin
          data_low_next = 1'b1;
          wd_cnt_next   = '0;
          state_next    = REQ;
        end else begin
          inh_cnt_next = inh_cnt + 1'b1;
        end
      end
      REQ: state_next = SEND;
      // The registered drive makes data move one cycle after the strobe, mid clock-low.
      SEND: begin
        if (fall) begin
          fall_cnt_next = fall_cnt + 4'd1;
          data_low_next = ~shift[0];
          shift_next    = {1'b0, shift[9:1]};
          if (fall_cnt == 4'd9) state_next = ACK;
        end
      end
      ACK: begin
        if (fall) begin
          fall_cnt_next = fall_cnt + 4'd1;
          if (!data_filt) begin
            state_next = WAIT_IDLE;
          end else begin
            tx_error   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_filt && data_filt) begin
          tx_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (wd_expired) begin
      tx_done       = 1'b0;
      tx_error      = 1'b1;
      data_low_next = 1'b0;
      state_next    = IDLE;
    end
  end

  assign tx_ready           = (state == IDLE);
  assign tx_busy            = (state != IDLE);
  assign ps2_clk_drive_low  = (state == INHIBIT);
  assign ps2_data_drive_low = data_low | ((state == INHIBIT) && inh_last);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a
// scoreboard queue holds each frame's expected outcome and bit pattern.
module tb_ps2_host_tx;

  localparam int INH        = 300;
  localparam int TMO        = 2000;
  localparam int HALF       = 40;
  localparam int DEV_ACK    = 0;
  localparam int DEV_NACK   = 1;
  localparam int DEV_SILENT = 2;

  typedef struct {
    logic        err;
    logic        chk_bits;
    logic        chk_tmo;
    logic [10:0] bits;
  } exp_t;

  logic       clk_100mhz = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_line, ps2_data_line;

  int          checks = 0;
  int          errors = 0;
  int          pulses_seen = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          inh_len = 0;
  logic        post_chk = 1'b0;
  int          dev_mode = DEV_ACK;
  logic        dev_abort = 1'b0;
  logic        dev_glitch = 1'b0;
  int          dev_falls = 0;
  logic [10:0] dev_bits = '0;
  exp_t        exp_q[$];

  assign ps2_clk_line  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(4)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst(rst),
    .ps2_clk_in(ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_error(tx_error),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_data_drive_low(ps2_data_drive_low)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic err, input logic chk_bits, input logic chk_tmo, input logic [10:0] bits);
    exp_t e;
    e.err = err;
    e.chk_bits = chk_bits;
    e.chk_tmo = chk_tmo;
    e.bits = bits;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    int k;
    @(negedge clk_100mhz);
    tx_data  = data;
    tx_valid = 1'b1;
    k = 0;
    while (tx_ready !== 1'b1 && k < 5000) begin
      @(negedge clk_100mhz);
      k++;
    end
    checkOutput("accept_ready", tx_ready, 1);
    @(posedge clk_100mhz);
    #1 tx_valid = 1'b0;
  endtask

  task automatic waitPulses(input int n);
    int k;
    k = 0;
    while (pulses_seen < n && k < 20000) begin
      @(negedge clk_100mhz);
      k++;
    end
    checkOutput("pulse_count", pulses_seen, n);
    repeat (200) @(negedge clk_100mhz);
  endtask

  // Device model: the host releasing clk is the first rising edge (start bit);
  // each later pulse is one fall followed by a rising-edge sample.
  initial begin
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    forever begin
      while (ps2_clk_drive_low !== 1'b1) @(negedge clk_100mhz);
      while (ps2_clk_drive_low === 1'b1) @(negedge clk_100mhz);
      dev_falls   = 0;
      dev_bits    = '0;
      dev_bits[0] = ps2_data_line;
      if (dev_mode != DEV_SILENT) begin
        repeat (20) @(negedge clk_100mhz);
        for (int i = 1; i <= 11; i++) begin
          if (dev_abort) break;
          if (i == 11 && dev_mode == DEV_ACK) begin
            dev_data_low = 1'b1;
            repeat (10) @(negedge clk_100mhz);
          end
          dev_clk_low = 1'b1;
          dev_falls   = i;
          repeat (HALF) @(negedge clk_100mhz);
          dev_clk_low = 1'b0;
          if (i <= 10) dev_bits[i] = ps2_data_line;
          dev_data_low = 1'b0;
          if (dev_glitch && i == 4) begin
            repeat (10) @(negedge clk_100mhz);
            dev_clk_low = 1'b1;
            repeat (3) @(negedge clk_100mhz);
            dev_clk_low = 1'b0;
            repeat (HALF - 13) @(negedge clk_100mhz);
          end else begin
            repeat (HALF) @(negedge clk_100mhz);
          end
        end
      end
    end
  end

  // Monitor: measures inhibit length and scores every done/error pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100mhz);
      cyc++;
      if (post_chk) begin
        post_chk = 1'b0;
        checkOutput("post_busy", tx_busy, 0);
        checkOutput("post_clk_drive", ps2_clk_drive_low, 0);
        checkOutput("post_data_drive", ps2_data_drive_low, 0);
      end
      if (ps2_clk_drive_low === 1'b1) begin
        inh_len++;
      end else if (inh_len != 0) begin
        checkOutput("inhibit_len", inh_len, INH);
        inh_len = 0;
        req_cyc = cyc;
      end
      if (rst === 1'b0 && (tx_done === 1'b1 || tx_error === 1'b1)) begin
        pulses_seen++;
        checkOutput("pulse_exclusive", tx_done & tx_error, 0);
        if (exp_q.size() == 0) begin
          checkOutput("pulse_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind_error", tx_error, e.err);
          if (e.chk_bits) checkOutput("frame_bits", dev_bits, e.bits);
          if (e.chk_tmo)  checkOutput("timeout_cycles", cyc - req_cyc, TMO);
          post_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int k;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (5) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    checkOutput("rst_ready", tx_ready, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_error", tx_error, 0);
    checkOutput("rst_clk_drive", ps2_clk_drive_low, 0);
    checkOutput("rst_data_drive", ps2_data_drive_low, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk_100mhz);

    // 0xED with ACK: start 0, ED LSB first, parity 1, stop 1
    dev_mode = DEV_ACK;
    pushExp(1'b0, 1'b1, 1'b0, 11'h7DA);
    applyStimulus(8'hED);
    waitPulses(1);

    // 0xFF with NACK
    dev_mode = DEV_NACK;
    pushExp(1'b1, 1'b1, 1'b0, 11'h7FE);
    applyStimulus(8'hFF);
    waitPulses(2);

    // silent device: watchdog expiry
    dev_mode = DEV_SILENT;
    pushExp(1'b1, 1'b0, 1'b1, 11'h000);
    applyStimulus(8'hA5);
    waitPulses(3);

    // reset after fall 5 of 0x00
    dev_mode = DEV_ACK;
    applyStimulus(8'h00);
    k = 0;
    while (dev_falls != 5 && k < 20000) begin
      @(negedge clk_100mhz);
      k++;
    end
    checkOutput("abort_fall5_reached", dev_falls, 5);
    k = 0;
    while (dev_clk_low && k < 1000) begin
      @(negedge clk_100mhz);
      k++;
    end
    repeat (5) @(negedge clk_100mhz);
    dev_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk_100mhz);
    checkOutput("abort_clk_drive", ps2_clk_drive_low, 0);
    checkOutput("abort_data_drive", ps2_data_drive_low, 0);
    checkOutput("abort_ready", tx_ready, 1);
    checkOutput("abort_done", tx_done, 0);
    checkOutput("abort_error", tx_error, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk_100mhz);
    dev_abort = 1'b0;
    pushExp(1'b0, 1'b1, 1'b0, 11'h5E8);
    applyStimulus(8'hF4);
    waitPulses(4);

    // tx_valid held across two frames: 0xED then 0x02
    pushExp(1'b0, 1'b1, 1'b0, 11'h7DA);
    pushExp(1'b0, 1'b1, 1'b0, 11'h404);
    @(negedge clk_100mhz);
    checkOutput("b2b_ready_first", tx_ready, 1);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(posedge clk_100mhz);
    #1 tx_data = 8'h02;
    k = 0;
    while (tx_done !== 1'b1 && k < 20000) begin
      @(negedge clk_100mhz);
      k++;
    end
    checkOutput("b2b_first_done", tx_done, 1);
    @(negedge clk_100mhz);
    checkOutput("b2b_ready_after_done", tx_ready, 1);
    @(posedge clk_100mhz);
    #1 tx_valid = 1'b0;
    checkOutput("b2b_second_busy", tx_busy, 1);
    waitPulses(6);

    // 3-cycle low glitch on ps2 clk during SEND
    dev_glitch = 1'b1;
    pushExp(1'b0, 1'b1, 1'b0, 11'h6AA);
    applyStimulus(8'h55);
    waitPulses(7);
    dev_glitch = 1'b0;

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
